p_1hot_chk_mon: RTL

Registered, multi-channel one-hot checker and error monitor. Each cycle it classifies N independent W-bit vectors as one-hot or not, with an optional zero-or-one-hot mode. It accumulates a saturating error count, a sticky error flag and a first-error capture record. It sits beside arbiters, muxes and FSM state registers as a runtime invariant monitor, feeding status/debug CSRs.

---
 rtl/p_1hot_chk_mon.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/p_1hot_chk_mon.sv
// p_1hot_chk_mon: registered multi-channel one-hot checker and error monitor.
// Each cycle, it classifies N vectors of W bits as one-hot or not. Optionally,
// the all-zero vector also passes. It keeps a saturating error count, a sticky
// error flag and a record of the first error.
// Optional feature: define P_1HOT_CHK_MON_THRESH_EN to add the i_thresh input
// and the o_irq output. o_irq is a registered threshold interrupt on the count.
//
// Handshake: i_vld[c] qualifies i_x[c] on every rising clk edge. There is no
// ready signal. The block accepts a new input every cycle and never stalls.
// o_vld[c] is i_vld[c] delayed by one cycle. o_is_1hot[c] is meaningful only
// when o_vld[c] is 1; otherwise it reads 0.
module p_1hot_chk_mon #(
    parameter int W          = 8,
    parameter int N          = 1,
    parameter int ALLOW_ZERO = 0,
    parameter int CNT_W      = 8,
    localparam int CH_W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          i_vld,
    input  logic [N-1:0][W-1:0]   i_x,
    input  logic                  i_clr,
`ifdef P_1HOT_CHK_MON_THRESH_EN
    input  logic [CNT_W-1:0]      i_thresh,
    output logic                  o_irq,
`endif
    output logic [N-1:0]          o_vld,
    output logic [N-1:0]          o_is_1hot,
    output logic                  o_err_sticky,
    output logic [CNT_W-1:0]      o_err_cnt,
    output logic                  o_first_err_vld,
    output logic [CH_W-1:0]       o_first_err_ch,
    output logic [W-1:0]          o_first_err_x
);

    localparam int PC_W  = $clog2(W + 1);
    // The sum is wide enough to hold the full count plus every channel
    // erroring in one cycle, so saturation never sees a wrapped value.
    localparam int SUM_W = CNT_W + $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N-1:0]      pass;
    logic [N-1:0]      err;
    logic [PC_W-1:0]   pc;
    logic [SUM_W-1:0]  n_err;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt_sat;
    logic [CH_W-1:0]   fe_ch;
    logic [W-1:0]      fe_x;

    logic [N-1:0]      vld_q, vld_d;
    logic [N-1:0]      is_1hot_q, is_1hot_d;
    logic              err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              first_err_vld_q, first_err_vld_d;
    logic [CH_W-1:0]   first_err_ch_q, first_err_ch_d;
    logic [W-1:0]      first_err_x_q, first_err_x_d;
`ifdef P_1HOT_CHK_MON_THRESH_EN
    logic              irq_q, irq_d;
`endif

    // Classify each channel by popcount and flag valid channels that fail.
    always_comb begin
        pass = '0;
        pc   = '0;
        for (int c = 0; c < N; c++) begin
            pc = '0;
            for (int b = 0; b < W; b++) begin
                pc = pc + PC_W'(i_x[c][b]);
            end
            pass[c] = (pc == PC_W'(1)) || ((ALLOW_ZERO != 0) && (pc == '0));
        end
        err = i_vld & ~pass;
    end

    // Count this cycle's errors, saturate the running total, and pick the
    // lowest-index erroring channel as the capture candidate.
    always_comb begin
        n_err = '0;
        fe_ch = '0;
        fe_x  = '0;
        for (int c = 0; c < N; c++) begin
            n_err = n_err + SUM_W'(err[c]);
        end
        for (int c = N - 1; c >= 0; c--) begin
            if (err[c]) begin
                fe_ch = CH_W'(c);
                fe_x  = i_x[c];
            end
        end
        sum     = SUM_W'(err_cnt_q) + n_err;
        cnt_sat = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end

    // Next-state for the monitor. A clear wins over any errors in the same cycle.
    always_comb begin
        vld_d           = i_vld;
        is_1hot_d       = i_vld & pass;
        err_sticky_d    = err_sticky_q;
        err_cnt_d       = err_cnt_q;
        first_err_vld_d = first_err_vld_q;
        first_err_ch_d  = first_err_ch_q;
        first_err_x_d   = first_err_x_q;
        if (i_clr) begin
            err_sticky_d    = 1'b0;
            err_cnt_d       = '0;
            first_err_vld_d = 1'b0;
            first_err_ch_d  = '0;
            first_err_x_d   = '0;
        end else begin
            err_cnt_d = cnt_sat;
            if (|err) begin
                err_sticky_d = 1'b1;
            end
            if (!first_err_vld_q && (|err)) begin
                first_err_vld_d = 1'b1;
                first_err_ch_d  = fe_ch;
                first_err_x_d   = fe_x;
            end
        end
`ifdef P_1HOT_CHK_MON_THRESH_EN
        // Compare against the post-update count so irq lines up with o_err_cnt.
        irq_d = !i_clr && (i_thresh != '0) && (err_cnt_d >= i_thresh);
`endif
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q           <= '0;
            is_1hot_q       <= '0;
            err_sticky_q    <= 1'b0;
            err_cnt_q       <= '0;
            first_err_vld_q <= 1'b0;
            first_err_ch_q  <= '0;
            first_err_x_q   <= '0;
`ifdef P_1HOT_CHK_MON_THRESH_EN
            irq_q           <= 1'b0;
`endif
        end else begin
            vld_q           <= vld_d;
            is_1hot_q       <= is_1hot_d;
            err_sticky_q    <= err_sticky_d;
            err_cnt_q       <= err_cnt_d;
            first_err_vld_q <= first_err_vld_d;
            first_err_ch_q  <= first_err_ch_d;
            first_err_x_q   <= first_err_x_d;
`ifdef P_1HOT_CHK_MON_THRESH_EN
            irq_q           <= irq_d;
`endif
        end
    end

    assign o_vld           = vld_q;
    assign o_is_1hot       = is_1hot_q;
    assign o_err_sticky    = err_sticky_q;
    assign o_err_cnt       = err_cnt_q;
    assign o_first_err_vld = first_err_vld_q;
    assign o_first_err_ch  = first_err_ch_q;
    assign o_first_err_x   = first_err_x_q;
`ifdef P_1HOT_CHK_MON_THRESH_EN
    assign o_irq           = irq_q;
`endif

endmodule
